// File: rtl/rnn_dense_pkg.sv
// Shared types and bus address map for the RNN dense/argmax output stage.
package rnn_dense_pkg;

  localparam int DW_DEF = 16;

  typedef logic signed [DW_DEF-1:0] elem_t;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

  // Write map
  localparam int ADDR_START      = 0;
  localparam int ADDR_HID        = 1;
  localparam int ADDR_W          = 2;
  localparam int ADDR_BIAS       = 3;
  localparam int ADDR_LOGIT_BASE = 16;

  // Read map for the low status words
  localparam int RD_STATUS = 0;
  localparam int RD_ARGMAX = 1;
  localparam int RD_MAX    = 2;

endpackage

// File: rtl/rnn_dense_argmax_mac.sv
// Single-MAC accumulator with bias add and DW-bit fit; DENSE_SAT_EN selects
// saturation instead of two's-complement wrap.
module dense_mac #(
  parameter int DW    = 16,
  parameter int N_HID = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] result
);

  // Wide enough for N_HID full-scale products plus the bias without overflow
  localparam int AW = 2*DW + $clog2(N_HID) + 1;

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_reg;
  logic signed [AW-1:0]   sum;

  assign prod = a * b;
  assign sum  = acc_reg + {{(AW-DW){bias[DW-1]}}, bias};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + {{(AW-2*DW){prod[2*DW-1]}}, prod};
    end
  end

`ifdef DENSE_SAT_EN
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    result = sum[DW-1:0];
    if (sum > SAT_HI) begin
      result = SAT_HI[DW-1:0];
    end else if (sum < SAT_LO) begin
      result = SAT_LO[DW-1:0];
    end
  end
`else
  assign result = sum[DW-1:0];
`endif

endmodule

// File: rtl/rnn_dense_argmax.sv
// Dense output layer (N_OUT logits from N_HID hidden values) with argmax select.
// Build option DENSE_SAT_EN saturates logits instead of wrapping (see dense_mac).
module rnn_dense_argmax
  import rnn_dense_pkg::*;
#(
  parameter int N_HID = 4,
  parameter int N_OUT = 8,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hid_valid,
  input  logic [N_HID*DW-1:0]        hid_in,
  input  logic                       read,
  input  logic                       write,
  input  logic [31:0]                addr,
  input  logic [31:0]                data_in,
  output logic [31:0]                data_out,
  output logic                       busy,
  output logic                       result_valid,
  output logic [$clog2(N_OUT)-1:0]   argmax_out
);

  localparam int OW = $clog2(N_OUT);
  localparam int IW = (N_HID > 1) ? $clog2(N_HID) : 1;

  state_t state_reg, state_next;
  logic [OW-1:0] o_reg, argmax_reg, argmax_out_reg;
  logic [IW-1:0] i_reg;
  logic          done_reg, busy_reg, rv_reg, mac_clr, mac_en, start;
  logic [31:0]   data_out_reg, rd_next;

  logic signed [DW-1:0] hid_vec   [N_HID];
  logic signed [DW-1:0] hid_reg   [N_HID];
  logic signed [DW-1:0] w_reg     [N_OUT][N_HID];
  logic signed [DW-1:0] bias_reg  [N_OUT];
  logic signed [DW-1:0] logit_reg [N_OUT];
  logic signed [DW-1:0] max_reg, fit_val, wr_val;

  for (genvar gi = 0; gi < N_HID; gi++) begin : g_hid_unpack
    assign hid_vec[gi] = hid_in[gi*DW +: DW];
  end

  assign wr_val = DW'($signed(data_in[15:0]));
  assign start  = write && !busy_reg && (addr == 32'(ADDR_START));

  function automatic logic [31:0] sext(input logic signed [DW-1:0] v);
    return {{(32-DW){v[DW-1]}}, v};
  endfunction

  // Parameter storage; everything is frozen while a computation is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_HID; k++) hid_reg[k] <= '0;
      for (int r = 0; r < N_OUT; r++) begin
        bias_reg[r] <= '0;
        for (int c = 0; c < N_HID; c++) w_reg[r][c] <= '0;
      end
    end else if (!busy_reg) begin
      for (int k = 0; k < N_HID; k++) begin
        if (hid_valid) begin
          hid_reg[k] <= hid_vec[k];
        end else if (write && addr == 32'(ADDR_HID) && data_in[31:16] == 16'(k)) begin
          hid_reg[k] <= wr_val;
        end
      end
      for (int r = 0; r < N_OUT; r++) begin
        if (write && addr == 32'(ADDR_BIAS) && data_in[31:16] == 16'(r)) begin
          bias_reg[r] <= wr_val;
        end
        for (int c = 0; c < N_HID; c++) begin
          if (write && addr == 32'(ADDR_W) && data_in[31:24] == 8'(r) &&
              data_in[23:16] == 8'(c)) begin
            w_reg[r][c] <= wr_val;
          end
        end
      end
    end
  end

  dense_mac #(.DW(DW), .N_HID(N_HID)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (w_reg[o_reg][i_reg]),
    .b      (hid_reg[i_reg]),
    .bias   (bias_reg[o_reg]),
    .result (fit_val)
  );

  always_comb begin
    state_next = state_reg;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        state_next = MAC;
        mac_clr    = 1'b1;
      end
      MAC: begin
        mac_en = 1'b1;
        if (i_reg == IW'(N_HID-1)) state_next = BIAS;
      end
      BIAS: begin
        mac_clr    = 1'b1;
        state_next = (o_reg == OW'(N_OUT-1)) ? DONE : MAC;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_next = '0;
    case (addr)
      32'(RD_STATUS): rd_next = {30'b0, done_reg, busy_reg};
      32'(RD_ARGMAX): rd_next = 32'(argmax_out_reg);
      32'(RD_MAX):    rd_next = sext(max_reg);
      default: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (addr == 32'(ADDR_LOGIT_BASE + k)) rd_next = sext(logit_reg[k]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      o_reg          <= '0;
      i_reg          <= '0;
      max_reg        <= '0;
      argmax_reg     <= '0;
      argmax_out_reg <= '0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      rv_reg         <= 1'b0;
      data_out_reg   <= '0;
      for (int k = 0; k < N_OUT; k++) logit_reg[k] <= '0;
    end else begin
      state_reg <= state_next;
      rv_reg    <= 1'b0;
      if (read) data_out_reg <= rd_next;
      case (state_reg)
        IDLE: if (start) begin
          o_reg    <= '0;
          i_reg    <= '0;
          busy_reg <= 1'b1;
          done_reg <= 1'b0;
        end
        MAC: i_reg <= (i_reg == IW'(N_HID-1)) ? '0 : i_reg + 1'b1;
        BIAS: begin
          logit_reg[o_reg] <= fit_val;
          // Strict compare: on ties the earlier (lower) index is kept
          if (o_reg == '0 || fit_val > max_reg) begin
            max_reg    <= fit_val;
            argmax_reg <= o_reg;
          end
          if (o_reg != OW'(N_OUT-1)) o_reg <= o_reg + 1'b1;
        end
        DONE: begin
          rv_reg         <= 1'b1;
          argmax_out_reg <= argmax_reg;
          done_reg       <= 1'b1;
          busy_reg       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign data_out     = data_out_reg;
  assign busy         = busy_reg;
  assign result_valid = rv_reg;
  assign argmax_out   = argmax_out_reg;

endmodule

// File: tb/tb_rnn_dense_argmax.sv
// Directed self-checking bench for rnn_dense_argmax (honours DENSE_SAT_EN).
module tb_rnn_dense_argmax;
  import rnn_dense_pkg::*;

  localparam int N_HID = 4;
  localparam int N_OUT = 8;
  localparam int DW    = 16;

  logic              clk, rst_n, hid_valid, read, write;
  logic [N_HID*DW-1:0] hid_in;
  logic [31:0]       addr, data_in, data_out;
  logic              busy, result_valid;
  logic [2:0]        argmax_out;

  int checks = 0, failures = 0, cyc = 0, rv_count = 0, t_start = 0;
  int exp_func [N_OUT] = '{-16, 7, 65, 0, 0, 0, 0, 0};
  int exp_tie  [N_OUT] = '{3, 3, 3, 3, 3, 3, 3, 3};
`ifdef DENSE_SAT_EN
  int exp_ovf  [N_OUT] = '{32767, 0, 0, 0, 0, 0, 0, 0};
  int exp_ovf_arg = 0, exp_ovf_max = 32767;
`else
  int exp_ovf  [N_OUT] = '{-5536, 0, 0, 0, 0, 0, 0, 0};
  int exp_ovf_arg = 1, exp_ovf_max = 0;
`endif

  rnn_dense_argmax #(.N_HID(N_HID), .N_OUT(N_OUT), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hid_valid    (hid_valid),
    .hid_in       (hid_in),
    .read         (read),
    .write        (write),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .busy         (busy),
    .result_valid (result_valid),
    .argmax_out   (argmax_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (result_valid === 1'b1) rv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] w_word(input int r, input int c, input int v);
    logic [31:0] t;
    t[31:24] = r[7:0];
    t[23:16] = c[7:0];
    t[15:0]  = v[15:0];
    return t;
  endfunction

  function automatic logic [31:0] idx_word(input int k, input int v);
    logic [31:0] t;
    t[31:16] = k[15:0];
    t[15:0]  = v[15:0];
    return t;
  endfunction

  task automatic bus_wr(input int a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; addr = 32'(a); data_in = d;
    @(negedge clk);
    write = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic bus_rd(input int a, output logic [31:0] d);
    @(negedge clk);
    read = 1'b1; addr = 32'(a);
    @(posedge clk);
    #1 d = data_out;
    read = 1'b0; addr = '0;
  endtask

  task automatic pulse_hid(input int e0, input int e1, input int e2, input int e3);
    @(negedge clk);
    hid_in = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    hid_valid = 1'b1;
    @(negedge clk);
    hid_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_compute(input string tag);
    @(negedge clk);
    write = 1'b1; addr = 32'(ADDR_START); data_in = '0;
    @(posedge clk);
    #1 t_start = cyc;
    write = 1'b0;
    check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_result(input string tag);
    int  n = 0, busy_gap = 0;
    bit  got = 0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1 n = cyc - t_start;
      if (result_valid === 1'b1) got = 1;
      else if (busy !== 1'b1) busy_gap++;
    end
    check({tag, "_rv_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(n), 32'd41);
      check({tag, "_busy_held"}, 32'(busy_gap), 32'd0);
      check({tag, "_busy_clear"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1 check({tag, "_rv_width"}, 32'(result_valid), 32'd0);
    end
  endtask

  task automatic check_results(input string tag, input int exp_l [N_OUT],
                               input int exp_arg, input int exp_max);
    logic [31:0] d;
    for (int k = 0; k < N_OUT; k++) begin
      bus_rd(ADDR_LOGIT_BASE + k, d);
      check($sformatf("%s_logit%0d", tag, k), d, 32'(exp_l[k]));
    end
    bus_rd(RD_MAX, d);
    check({tag, "_max"}, d, 32'(exp_max));
    bus_rd(RD_ARGMAX, d);
    check({tag, "_argmax_rd"}, d, 32'(exp_arg));
    check({tag, "_argmax_out"}, 32'(argmax_out), 32'(exp_arg));
  endtask

  initial begin
    logic [31:0] d;
    int rv_snap;
    elem_t h0;
    rst_n = 1'b1; hid_valid = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; data_in = '0; hid_in = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data_out", data_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_argmax", 32'(argmax_out), 32'd0);
    rst_n = 1'b1;

    // Functional case
    pulse_hid(-16, -49, -57, 2);
    bus_wr(ADDR_W, w_word(0, 0, 1));
    bus_wr(ADDR_W, w_word(1, 3, 1));
    bus_wr(ADDR_W, w_word(2, 0, -1));
    bus_wr(ADDR_W, w_word(2, 1, -1));
    bus_wr(ADDR_BIAS, idx_word(1, 5));
    start_compute("func");
    wait_result("func");
    check_results("func", exp_func, 2, 65);
    bus_rd(RD_STATUS, d);
    check("func_status", d, 32'h2);

    // Busy lockout: writes, hid_valid and a second start during compute are ignored
    start_compute("lock");
    repeat (4) @(posedge clk);
    bus_wr(ADDR_W, w_word(2, 0, 99));
    pulse_hid(1, 1, 1, 1);
    bus_wr(ADDR_HID, idx_word(0, 7));
    bus_wr(ADDR_START, 32'd0);
    wait_result("lock");
    check_results("lock", exp_func, 2, 65);

    // Reset during MAC aborts the computation and clears results
    bus_rd(RD_MAX, d);
    check("pre_rst_max", d, 32'd65);
    start_compute("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_out", data_out, 32'd0);
    check("abort_rv", 32'(result_valid), 32'd0);
    check("abort_argmax", 32'(argmax_out), 32'd0);
    rv_snap = rv_count;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_rv", 32'(rv_count - rv_snap), 32'd0);
    bus_rd(RD_MAX, d);
    check("abort_max", d, 32'd0);
    bus_rd(RD_STATUS, d);
    check("abort_status", d, 32'd0);

    // Ties: zero weights (cleared by reset), every bias 3
    for (int k = 0; k < N_OUT; k++) bus_wr(ADDR_BIAS, idx_word(k, 3));
    start_compute("tie");
    wait_result("tie");
    check_results("tie", exp_tie, 0, 3);

    // Overflow: 300*200 = 60000 does not fit in 16 bits
    apply_reset();
    h0 = 16'sd300;
    bus_wr(ADDR_HID, idx_word(0, int'(h0)));
    bus_wr(ADDR_W, w_word(0, 0, 200));
    start_compute("ovf");
    wait_result("ovf");
    check_results("ovf", exp_ovf, exp_ovf_arg, exp_ovf_max);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
